dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 32, data width.
- WAIT_CYCLES, 1, extra memory cycles per access (0..15).
- STARVE_LIM, 4, cycles the external requester may wait before forced grant (1..15).

REQ-002 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- pipe_req, in, 1, MEM-stage access request (data_read OR data_write).
- pipe_we, in, 1, 1 = write, 0 = read.
- pipe_addr, in, ADDR_W, address.
- pipe_wdata, in, DATA_W, store data.
- pipe_rdata, out, DATA_W, load data, valid in the completion cycle.
- pipe_stall, out, 1, freezes the PC and all pipeline registers.
- ext_req, in, 1, loader/debug access request.
- ext_we, in, 1, 1 = write, 0 = read.
- ext_addr, in, ADDR_W, address.
- ext_wdata, in, DATA_W, write data.
- ext_gnt, out, 1, external access in progress.
- ext_ack, out, 1, one-cycle completion pulse.
- ext_rdata, out, DATA_W, read data, valid while ext_ack=1.
- mem_en, out, 1, memory enable.
- mem_we, out, 1, memory write strobe.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data, valid in the last cycle of an access.

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, PIPE_ACC and EXT_ACC.
REQ-004 In IDLE, the block SHALL move to EXT_ACC if ext_req=1 and starve_cnt>=STARVE_LIM; otherwise to PIPE_ACC if pipe_req=1; otherwise to EXT_ACC if ext_req=1; otherwise it SHALL stay in IDLE.
REQ-005 On leaving IDLE, the block SHALL latch the winner's we, addr and wdata and SHALL load wait_cnt=WAIT_CYCLES.
REQ-006 In PIPE_ACC and EXT_ACC, the block SHALL drive mem_en=1, with mem_addr and mem_wdata taken from the latched command and held stable for the whole access.
REQ-007 In PIPE_ACC and EXT_ACC, wait_cnt SHALL decrement each cycle while nonzero; the cycle with wait_cnt=0 is the completion cycle, and the next state SHALL be IDLE.
REQ-008 The block SHALL assert mem_we only in the completion cycle and only when the latched we=1, giving exactly one write per access.
REQ-009 The block SHALL drive pipe_stall combinationally as pipe_req AND NOT (state=PIPE_ACC AND wait_cnt=0); every pipeline access therefore stalls for WAIT_CYCLES+1 cycles.
REQ-010 The block SHALL drive pipe_rdata = mem_rdata in the PIPE_ACC completion cycle and 0 otherwise.
REQ-011 The block SHALL hold ext_gnt=1 throughout EXT_ACC.
REQ-012 The block SHALL pulse ext_ack=1 for exactly the EXT_ACC completion cycle, with ext_rdata=mem_rdata in that cycle; ext_rdata SHALL be 0 otherwise.
REQ-013 The external requester holds ext_req and its command stable until ext_ack; if ext_req drops mid-access, the access SHALL still complete and ext_ack SHALL still pulse.
REQ-014 starve_cnt (4 bits) SHALL increment, saturating at 15, each cycle that ext_req=1 and state!=EXT_ACC, and SHALL clear on entry to EXT_ACC.
REQ-015 A forced external grant SHALL keep pipe_stall=1 until the following pipeline access completes.
REQ-016 Pipeline requests arriving in any non-IDLE state SHALL wait, with stall asserted, and SHALL be served in the next IDLE cycle per REQ-004.
REQ-017 Every access SHALL pass through IDLE for one cycle before the next grant; there SHALL be no back-to-back grant.
REQ-018 If both requests are present and starve_cnt<STARVE_LIM, the pipeline SHALL win.

Reset
REQ-019 While reset=0, the block SHALL set state=IDLE and clear wait_cnt, starve_cnt and latched command registers to 0, and SHALL drive all outputs to 0, independent of clk.
REQ-020 Reset asserted mid-access SHALL abandon the access with no mem_we pulse and no ext_ack, and the block SHALL restart in IDLE on deassertion.

Verification
REQ-021 Pipeline read with WAIT_CYCLES=1: pipe_req=1, pipe_we=0, addr 0x10, memory holding 0x12345678 -> pipe_stall=1 for 2 cycles, then 0 with pipe_rdata=0x12345678.
REQ-022 Pipeline write: addr 0x20, data 0xDEADBEEF -> single mem_we pulse in the completion cycle; a subsequent read of 0x20 returns 0xDEADBEEF.
REQ-023 External read while pipe_req=0 -> ext_gnt high 2 cycles, ext_ack single pulse, ext_rdata correct, pipe_stall=0 throughout.
REQ-024 Starvation: pipe_req held at 1 continuously, ext_req asserted -> after starve_cnt reaches 4, the next IDLE grants EXT_ACC, pipe_stall stays 1, and the pipeline is served immediately after.
REQ-025 Simultaneous: both requests rise in the same IDLE cycle with starve_cnt=0 -> PIPE_ACC first, EXT_ACC after one IDLE cycle.
REQ-026 Reset: reset=0 asserted in the middle of an EXT_ACC write -> outputs 0 asynchronously, memory contents unchanged, no ext_ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage and an
// external loader/debug requester, with starvation-bounded priority for the pipeline.
module dmem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_LIM  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, PIPE_ACC, EXT_ACC} state_t;
    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pipe_acc, ext_acc, acc, done, grant, ext_win;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end
    always_comb begin
        pipe_acc = state_q == PIPE_ACC;
        ext_acc  = state_q == EXT_ACC;
        acc      = pipe_acc | ext_acc;
        done     = acc && wait_cnt_q == 4'd0;
    end
    // A starved external requester outranks the pipeline; otherwise the pipeline wins.
    always_comb begin
        state_d = (state_q == IDLE) ?
                  ((ext_req && starve_cnt_q >= 4'(STARVE_LIM)) ? EXT_ACC :
                   pipe_req ? PIPE_ACC : ext_req ? EXT_ACC : IDLE) :
                  done ? IDLE : state_q;
    end
    always_comb begin
        grant        = state_q == IDLE && state_d != IDLE;
        ext_win      = state_d == EXT_ACC;
        we_d         = grant ? (ext_win ? ext_we : pipe_we) : we_q;
        addr_d       = grant ? (ext_win ? ext_addr : pipe_addr) : addr_q;
        wdata_d      = grant ? (ext_win ? ext_wdata : pipe_wdata) : wdata_q;
        wait_cnt_d   = grant ? 4'(WAIT_CYCLES) :
                       (wait_cnt_q != 4'd0) ? wait_cnt_q - 4'd1 : wait_cnt_q;
        starve_cnt_d = (grant && ext_win) ? 4'd0 :
                       (ext_req && !ext_acc && starve_cnt_q != 4'hf) ? starve_cnt_q + 4'd1 :
                       starve_cnt_q;
    end
    // Stall is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        mem_en     = acc;
        mem_we     = done & we_q;
        mem_addr   = acc ? addr_q : '0;
        mem_wdata  = acc ? wdata_q : '0;
        pipe_stall = reset & pipe_req & ~(pipe_acc & done);
        pipe_rdata = (pipe_acc && done) ? mem_rdata : '0;
        ext_gnt    = ext_acc;
        ext_ack    = ext_acc & done;
        ext_rdata  = (ext_acc && done) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a simple synchronous-write
// memory, covering reads, writes, external access, arbitration, starvation and reset.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_we, ext_req, ext_we;
    logic [7:0]  pipe_addr, ext_addr;
    logic [31:0] pipe_wdata, ext_wdata;
    logic [31:0] pipe_rdata, ext_rdata, mem_wdata, mem_rdata;
    logic        pipe_stall, ext_gnt, ext_ack, mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata), .pipe_stall(pipe_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        cyc();
        pl_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {pipe_req, pipe_we, ext_req, ext_we} = '0;
        pipe_addr = '0; ext_addr = '0; pipe_wdata = '0; ext_wdata = '0;
        #2;
        pipe_req = 1'b1;
        #1;
        chk("rst_stall", 32'(pipe_stall), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_gnt", 32'(ext_gnt), 0);
        pipe_req = 1'b0;
        preload(8'h10, 32'h12345678);
        preload(8'h20, 32'h0);
        preload(8'h30, 32'hCAFEF00D);
        preload(8'h40, 32'h0);
        reset = 1'b1;
        cyc();
        // pipeline read
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 8'h10;
        #1;
        chk("rd_idle_stall", 32'(pipe_stall), 1);
        chk("rd_idle_en", 32'(mem_en), 0);
        cyc();
        chk("rd_w1_stall", 32'(pipe_stall), 1);
        chk("rd_w1_en", 32'(mem_en), 1);
        chk("rd_w1_addr", 32'(mem_addr), 32'h10);
        chk("rd_w1_rdata", pipe_rdata, 0);
        cyc();
        chk("rd_done_stall", 32'(pipe_stall), 0);
        chk("rd_done_rdata", pipe_rdata, 32'h12345678);
        chk("rd_done_we", 32'(mem_we), 0);
        pipe_req = 1'b0;
        cyc();
        chk("rd_back_idle", 32'(mem_en), 0);
        // pipeline write
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 8'h20; pipe_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_idle_we", 32'(mem_we), 0);
        cyc();
        chk("wr_w1_we", 32'(mem_we), 0);
        chk("wr_w1_wdata", mem_wdata, 32'hDEADBEEF);
        cyc();
        chk("wr_done_we", 32'(mem_we), 1);
        chk("wr_done_stall", 32'(pipe_stall), 0);
        pipe_req = 1'b0; pipe_we = 1'b0;
        cyc();
        chk("wr_after_we", 32'(mem_we), 0);
        chk("wr_mem", mem[8'h20], 32'hDEADBEEF);
        pipe_req = 1'b1; pipe_addr = 8'h20;
        cyc();
        cyc();
        chk("wr_readback", pipe_rdata, 32'hDEADBEEF);
        pipe_req = 1'b0;
        cyc();
        // external read, pipeline quiet
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h30;
        #1;
        chk("ext_idle_gnt", 32'(ext_gnt), 0);
        cyc();
        chk("ext_w1_gnt", 32'(ext_gnt), 1);
        chk("ext_w1_ack", 32'(ext_ack), 0);
        chk("ext_w1_rdata", ext_rdata, 0);
        chk("ext_w1_stall", 32'(pipe_stall), 0);
        cyc();
        chk("ext_done_gnt", 32'(ext_gnt), 1);
        chk("ext_done_ack", 32'(ext_ack), 1);
        chk("ext_done_rdata", ext_rdata, 32'hCAFEF00D);
        chk("ext_done_stall", 32'(pipe_stall), 0);
        ext_req = 1'b0;
        cyc();
        chk("ext_after_gnt", 32'(ext_gnt), 0);
        chk("ext_after_ack", 32'(ext_ack), 0);
        // simultaneous requests, pipeline first
        pipe_req = 1'b1; pipe_addr = 8'h10; ext_req = 1'b1; ext_addr = 8'h30;
        cyc();
        chk("sim_pipe_first", 32'(ext_gnt), 0);
        chk("sim_pipe_en", 32'(mem_addr), 32'h10);
        cyc();
        chk("sim_pipe_rdata", pipe_rdata, 32'h12345678);
        pipe_req = 1'b0;
        cyc();
        chk("sim_idle_gap_en", 32'(mem_en), 0);
        chk("sim_idle_gap_gnt", 32'(ext_gnt), 0);
        cyc();
        chk("sim_ext_gnt", 32'(ext_gnt), 1);
        cyc();
        chk("sim_ext_ack", 32'(ext_ack), 1);
        chk("sim_ext_rdata", ext_rdata, 32'hCAFEF00D);
        ext_req = 1'b0;
        cyc();
        // starvation: pipe_req held, ext forced in after starve_cnt passes the limit
        pipe_req = 1'b1; pipe_addr = 8'h10; ext_req = 1'b1; ext_addr = 8'h30;
        cyc();
        cyc();
        chk("stv_p1_done", 32'(pipe_stall), 0);
        cyc();
        chk("stv_idle2_en", 32'(mem_en), 0);
        cyc();
        chk("stv_p2_gnt", 32'(ext_gnt), 0);
        chk("stv_p2_en", 32'(mem_en), 1);
        cyc();
        chk("stv_p2_done", 32'(pipe_stall), 0);
        cyc();
        chk("stv_idle3_stall", 32'(pipe_stall), 1);
        cyc();
        chk("stv_forced_gnt", 32'(ext_gnt), 1);
        chk("stv_forced_stall", 32'(pipe_stall), 1);
        cyc();
        chk("stv_forced_ack", 32'(ext_ack), 1);
        chk("stv_ack_stall", 32'(pipe_stall), 1);
        ext_req = 1'b0;
        cyc();
        chk("stv_idle4_stall", 32'(pipe_stall), 1);
        cyc();
        chk("stv_pipe_back", 32'(mem_addr), 32'h10);
        cyc();
        chk("stv_pipe_served", 32'(pipe_stall), 0);
        chk("stv_pipe_rdata", pipe_rdata, 32'h12345678);
        pipe_req = 1'b0;
        cyc();
        // reset during an external write
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h40; ext_wdata = 32'h11112222;
        cyc();
        chk("rw_gnt", 32'(ext_gnt), 1);
        chk("rw_we0", 32'(mem_we), 0);
        reset = 1'b0;
        #1;
        chk("rw_async_gnt", 32'(ext_gnt), 0);
        chk("rw_async_en", 32'(mem_en), 0);
        chk("rw_async_we", 32'(mem_we), 0);
        chk("rw_async_addr", 32'(mem_addr), 0);
        chk("rw_async_ack", 32'(ext_ack), 0);
        ext_req = 1'b0; ext_we = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("rw_post_ack", 32'(ext_ack), 0);
        chk("rw_post_en", 32'(mem_en), 0);
        chk("rw_mem_kept", mem[8'h40], 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
